// File: rtl/add_unit_arbiter.sv
// rtl/add_unit_arbiter.sv - round-robin arbiter sharing one adder among NUM_REQ issuing requesters
module add_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH:0]             add_out,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [WIDTH:0]             wb_result,
    output logic [2:0]                 wb_src,
    output logic [TAG_W-1:0]           wb_tag,
    output logic                       busy,
    output logic [15:0]                issue_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   src_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [TAG_W-1:0]   tag_q;
    logic [7:0]         cnt_q;
    logic [WIDTH:0]     res_q;
    logic [15:0]        issue_q;
    logic               wb_valid_q, busy_q;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [TAG_W-1:0]   t_arr [NUM_REQ];

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
            t_arr[i] = req_tag[i*TAG_W +: TAG_W];
        end
    end

    // Scan upward from the pointer, wrapping, and take the first valid requester.
    always_comb begin
        int j;
        j           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_found && req_valid[j[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign accept = (state_q == IDLE) && |(req_valid & req_ready);
    assign ptr_d  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            src_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            issue_q    <= '0;
            wb_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q     <= a_arr[grant_idx];
                    b_q     <= b_arr[grant_idx];
                    tag_q   <= t_arr[grant_idx];
                    src_q   <= grant_idx;
                    ptr_q   <= ptr_d;
                    issue_q <= issue_q + 16'd1;
                    cnt_q   <= 8'(ADD_LAT);
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                // Counter reaching zero means add_out reflects the held operands.
                EXEC: if (cnt_q == 8'd0) begin
                    res_q      <= add_out;
                    wb_valid_q <= 1'b1;
                    state_q    <= WB;
                end else begin
                    cnt_q <= cnt_q - 8'd1;
                end
                WB: if (wb_ready) begin
                    wb_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a       = a_q;
    assign add_b       = b_q;
    assign wb_valid    = wb_valid_q;
    assign wb_result   = res_q;
    assign wb_src      = 3'(src_q);
    assign wb_tag      = tag_q;
    assign busy        = busy_q;
    assign issue_count = issue_q;

endmodule

// File: tb/tb_add_unit_arbiter.sv
// tb/tb_add_unit_arbiter.sv - scoreboard bench for add_unit_arbiter with a registered adder model
module tb_add_unit_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int T = 4;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*T-1:0]  req_tag;
    logic [W-1:0]    add_a, add_b;
    logic [W:0]      add_out;
    logic            wb_valid, wb_ready;
    logic [W:0]      wb_result;
    logic [2:0]      wb_src;
    logic [T-1:0]    wb_tag;
    logic            busy;
    logic [15:0]     issue_count;

    logic [W-1:0]    op_a [N];
    logic [W-1:0]    op_b [N];
    logic [T-1:0]    op_t [N];

    typedef struct {
        logic [W:0]   res;
        int           src;
        logic [T-1:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [W:0]  got_res[$];
    int          got_src[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_state, m_cnt, m_ptr;
    logic [15:0] m_issue;
    bit          mon_en = 1'b0;

    add_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .TAG_W(T), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_src(wb_src), .wb_tag(wb_tag),
        .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) add_out <= '0;
        else     add_out <= {1'b0, add_a} + {1'b0, add_b};
    end

    always_comb begin
        req_a = '0; req_b = '0; req_tag = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]   = op_a[i];
            req_b[i*W +: W]   = op_b[i];
            req_tag[i*T +: T] = op_t[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial forever begin
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        if (rst) begin
            m_state = 0; m_ptr = 0; m_cnt = 0; m_issue = '0;
            exp_q.delete();
        end else if (mon_en) begin
            chk("busy", busy, m_state != 0);
            chk("wb_valid", wb_valid, m_state == 2);
            chk("issue_count", issue_count, m_issue);
            g  = rr_pick(req_valid, m_ptr);
            er = (m_state == 0 && g >= 0) ? N'(1 << g) : '0;
            chk("req_ready", req_ready, er);
            if (m_state == 2) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    chk("wb_result", wb_result, exp_q[0].res);
                    chk("wb_src", wb_src, exp_q[0].src);
                    chk("wb_tag", wb_tag, exp_q[0].tag);
                    if (wb_ready) begin
                        got_res.push_back(wb_result);
                        got_src.push_back(int'(wb_src));
                        void'(exp_q.pop_front());
                        m_state = 0;
                    end
                end
            end else if (m_state == 1) begin
                if (m_cnt == 0) m_state = 2;
                else m_cnt--;
            end else if (g >= 0) begin
                exp_q.push_back('{res: {1'b0, op_a[g]} + {1'b0, op_b[g]}, src: g, tag: op_t[g]});
                m_ptr   = (g + 1) % N;
                m_state = 1;
                m_cnt   = LAT;
                m_issue = m_issue + 16'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        logic [15:0] base = m_issue;
        int k = 0;
        while (m_issue == base && k < 50) begin tick(1); k++; end
        if (m_issue == base) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || m_state != 0) && k < 100) begin tick(1); k++; end
        if (exp_q.size() != 0 || m_state != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] t);
        op_a[idx] = a; op_b[idx] = b; op_t[idx] = t;
        req_valid[idx] = 1'b1;
        wait_accept();
        req_valid[idx] = 1'b0;
        wait_idle();
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_add_a"}, add_a, 0);
        chk({pfx, "_add_b"}, add_b, 0);
        chk({pfx, "_wb_result"}, wb_result, 0);
        chk({pfx, "_wb_src"}, wb_src, 0);
        chk({pfx, "_wb_tag"}, wb_tag, 0);
        chk({pfx, "_issue_count"}, issue_count, 0);
        chk({pfx, "_wb_valid"}, wb_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        int exp_src [5] = '{0, 1, 2, 3, 0};
        int exp_res [5] = '{6, 7, 8, 9, 6};
        rst = 1'b1; wb_ready = 1'b1; req_valid = '0;
        for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_t[i] = '0; end
        #1;
        chk_all_zero("rst0");
        tick(3);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(3);

        // round-robin with all requesters held valid
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(i + 1); op_b[i] = 16'd5; op_t[i] = T'(i + 8);
        end
        got_src.delete(); got_res.delete();
        req_valid = '1;
        for (int n = 0; n < 5; n++) wait_accept();
        req_valid = '0;
        wait_idle();
        chk("rr_count", got_src.size(), 5);
        for (int i = 0; i < 5 && i < got_src.size(); i++) begin
            chk("rr_order", got_src[i], exp_src[i]);
            chk("rr_result", got_res[i], exp_res[i]);
        end

        // single operation
        issue_one(0, 16'd10, 16'd54, 4'd3);
        chk("single_result", got_res[$], 17'd64);
        chk("single_src", got_src[$], 0);
        chk("single_tag", wb_tag, 4'd3);
        chk("single_issue", issue_count, 16'd6);

        // carry out
        issue_one(2, 16'hFFFF, 16'h0001, 4'd5);
        chk("carry1", got_res[$], 17'h10000);
        issue_one(2, 16'hFFFF, 16'hFFFF, 4'd6);
        chk("carry2", got_res[$], 17'h1FFFE);

        // write-back back-pressure with another requester waiting
        wb_ready = 1'b0;
        op_a[3] = 16'd100; op_b[3] = 16'd200; op_t[3] = 4'd9;
        req_valid[3] = 1'b1;
        wait_accept();
        req_valid[3] = 1'b0;
        op_a[1] = 16'd7; op_b[1] = 16'd8; op_t[1] = 4'd1;
        req_valid[1] = 1'b1;
        begin
            int k = 0;
            while (!wb_valid && k < 20) begin tick(1); k++; end
            chk("bp_wb_seen", wb_valid, 1);
        end
        tick(5);
        chk("bp_held_result", wb_result, 17'd300);
        wb_ready = 1'b1;
        tick(1);
        chk("bp_no_accept_in_hs", issue_count, 16'd9);
        wait_accept();
        req_valid[1] = 1'b0;
        wait_idle();
        chk("bp_next_src", got_src[$], 1);
        chk("bp_next_result", got_res[$], 17'd15);

        // reset during EXEC discards the operation and restarts the pointer
        op_a[1] = 16'd1; op_b[1] = 16'd5; op_t[1] = 4'd2;
        req_valid[1] = 1'b1;
        wait_accept();
        req_valid[1] = 1'b0;
        op_a[0] = 16'd20; op_b[0] = 16'd22; op_t[0] = 4'd4;
        op_a[2] = 16'd3;  op_b[2] = 16'd4;  op_t[2] = 4'd7;
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_exec");
        tick(2);
        rst = 1'b0;
        got_src.delete(); got_res.delete();
        wait_accept();
        wait_accept();
        req_valid = '0;
        wait_idle();
        chk("post_rst_count", got_src.size(), 2);
        if (got_src.size() == 2) begin
            chk("post_rst_first", got_src[0], 0);
            chk("post_rst_first_res", got_res[0], 17'd42);
            chk("post_rst_second", got_src[1], 2);
            chk("post_rst_second_res", got_res[1], 17'd7);
        end
        chk("post_rst_issue", issue_count, 16'd2);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/add_unit_arbiter.md
Name: add_unit_arbiter

Overview:
- Shares one 16-bit carry-lookahead adder functional unit (17-bit sum output) between NUM_REQ issuing requesters, in the scoreboard issue/execute/write-back style.
- Grants one requester at a time using round-robin priority.
- Drives the adder operands, waits the adder latency, then holds the tagged result on a write-back bus until it is accepted.
- Sits between the scoreboard issue logic and the adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width; the result is WIDTH+1 bits.
- TAG_W, 4, destination tag width.
- ADD_LAT, 1, clock edges from stable operands to a valid add_out (0 = combinational adder, 1 = registered adder).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing.
- req_tag  in  NUM_REQ*TAG_W  packed destination tags.
- add_a  out  WIDTH  operand A to the adder.
- add_b  out  WIDTH  operand B to the adder.
- add_out  in  WIDTH+1  sum from the adder.
- wb_valid  out  1  write-back result valid.
- wb_ready  in  1  write-back accept.
- wb_result  out  WIDTH+1  sum, carry in the MSB.
- wb_src  out  3  index of the requester that owns the result.
- wb_tag  out  TAG_W  destination tag of the result.
- busy  out  1  functional unit occupied.
- issue_count  out  16  number of accepted operations, wraps.

Behaviour:
- Reset (asynchronous, immediate):
  - state goes to IDLE; the round-robin pointer goes to 0.
  - add_a, add_b, wb_result, wb_src, wb_tag, issue_count, the latency counter and all captured registers go to 0.
  - wb_valid=0, busy=0, req_ready=0.
  - Reset mid-operation discards the in-flight operation; no write-back is produced.
- States: IDLE, EXEC, WB. Single issue only, no pipelining.
- IDLE:
  - req_ready is combinational and is nonzero only in IDLE.
  - Grant g = first i with req_valid[i]=1, scanning from the pointer upward modulo NUM_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - If no request is valid, req_ready=0 and the state stays IDLE.
- Accept edge (IDLE with req_valid[g] & req_ready[g]):
  - Capture the slice a/b/tag of g, and capture g as the source.
  - pointer <= (g+1) mod NUM_REQ.
  - issue_count <= issue_count+1, wrapping 0xFFFF to 0.
  - Load the counter with ADD_LAT and go to EXEC.
- EXEC:
  - add_a/add_b are driven from the captured registers; they are stable from the first EXEC cycle until the next accept.
  - The counter decrements each cycle.
  - When the counter is 0, add_out is sampled into wb_result at that edge and the state goes to WB.
  - EXEC lasts ADD_LAT+1 cycles.
- WB:
  - wb_valid=1; wb_result, wb_src and wb_tag are held stable.
  - On wb_valid & wb_ready, the state goes to IDLE.
  - No new request is accepted in the handshake cycle; the earliest next accept is the following cycle.
  - wb_valid deasserts the cycle after the handshake.
- Latency: wb_valid rises ADD_LAT+2 cycles after the accept edge. With ADD_LAT=1: accept at cycle T, wb_valid in T+3.
- Best throughput: one operation per ADD_LAT+3 cycles.
- busy=1 in EXEC and WB, 0 in IDLE.
- Arithmetic: wb_result = zero-extended a + b, taken exactly from add_out; the arbiter does no arithmetic of its own.
- Requester rules:
  - A requester may drop req_valid before it is granted; nothing is captured for it.
  - A requester's operands are sampled only on its accept edge.
- Simultaneous requests: only the round-robin winner is granted. A requester that is held off is served within NUM_REQ grants.
- The add_a/add_b held values persist in IDLE until the next accept.

Test Plan:
1. Reset: assert rst mid-cycle -> all outputs 0 immediately; after release, with no requests, req_ready=0 and busy=0.
2. Single operation, ADD_LAT=1: req 0, a=10, b=54, tag=3, accepted at T -> wb_valid at T+3 with wb_result=64, wb_src=0, wb_tag=3; issue_count=1.
3. Round-robin: all 4 requesters valid continuously, with a=i+1, b=5 -> grant order 0,1,2,3,0; results 6,7,8,9,6; wb_ready tied high.
4. Carry: a=0xFFFF, b=0x0001 -> wb_result=0x10000; a=0xFFFF, b=0xFFFF -> 0x1FFFE.
5. Back-pressure: wb_ready low for 5 cycles during WB -> wb_valid held, result stable, req_ready=0 throughout; on the handshake cycle no accept occurs, and the next grant is the cycle after.
6. Reset during EXEC (a=1, b=5 in flight) -> no wb_valid ever appears for it; after release, the pointer restarts at 0 and requester 0 wins over requester 2.
